// File: rtl/mat_pkg.sv
// Shared types and element-offset helpers for the mat_mul stream front end.
package mat_pkg;

    localparam int EXP_WIDTH_DEF = 8;
    localparam int MAN_WIDTH_DEF = 23;

    // Width of one float word: sign, exponent and mantissa.
    function automatic int float_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    localparam int FW = float_width(EXP_WIDTH_DEF, MAN_WIDTH_DEF);

    // Width of a flat matrix bus holding rows*cols float words.
    function automatic int mat_width(input int rows, input int cols, input int fw = FW);
        return rows * cols * fw;
    endfunction

    // LSB of element (r,c) in a row-major flat bus with 'cols' columns.
    function automatic int mat_lsb(input int r, input int c, input int cols, input int fw = FW);
        return (r * cols + c) * fw;
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        WAIT,
        DRAIN
    } mat_io_state_t;

endpackage

// File: rtl/mat_flat_unpack.sv
// Selects one float word out of a row-major flat matrix bus by linear index.
module mat_flat_unpack
    import mat_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ELEM_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic [mat_width(ROWS, COLS, ELEM_W)-1:0] flat,
    input  logic [IDX_W-1:0]                         idx,
    output logic [ELEM_W-1:0]                        elem
);

    // Index-to-slice mux; indices past the last element read as zero.
    always_comb begin
        elem = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (int'(idx) == r * COLS + c) begin
                    elem = flat[mat_lsb(r, c, COLS, ELEM_W) +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: rtl/mat_stream_io.sv
// Stream front end for mat_mul: packs incoming float words into the mat1/mat2
// operand buses, waits out the multiplier latency, captures matr and replays
// it row-major on a valid/ready output stream.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   LOAD_A | accepting mat1 words, row-major, idx = element being written
//   LOAD_B | accepting mat2 words, row-major, idx = element being written
//   WAIT   | operands stable, wcnt counts edges until matr is valid
//   DRAIN  | presenting result word idx; advances on each output transfer
module mat_stream_io
    import mat_pkg::*;
#(
    parameter  int I           = 4,
    parameter  int J           = 4,
    parameter  int K           = 4,
    parameter  int EXP_WIDTH   = 8,
    parameter  int MAN_WIDTH   = 23,
    parameter  int MUL_LATENCY = 1,
    localparam int ELEM_W      = float_width(EXP_WIDTH, MAN_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ELEM_W-1:0]                    in_data,
    output logic [mat_width(I, J, ELEM_W)-1:0]   mat1,
    output logic [mat_width(J, K, ELEM_W)-1:0]   mat2,
    input  logic [mat_width(I, K, ELEM_W)-1:0]   matr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ELEM_W-1:0]                    out_data,
    output logic                                 out_last
);

    localparam int NA     = I * J;
    localparam int NB     = J * K;
    localparam int NR     = I * K;
    localparam int N_MAX  = (NA > NB) ? ((NA > NR) ? NA : NR) : ((NB > NR) ? NB : NR);
    localparam int IDX_W  = idx_width(N_MAX);
    localparam int WCNT_W = idx_width(MUL_LATENCY);

    localparam logic [IDX_W-1:0]  IDX_LAST_A = IDX_W'(NA - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST_B = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST_R = IDX_W'(NR - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(MUL_LATENCY - 1);

    mat_io_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [WCNT_W-1:0]                   wcnt_q, wcnt_d;
    logic [mat_width(I, J, ELEM_W)-1:0]  mat1_q, mat1_d;
    logic [mat_width(J, K, ELEM_W)-1:0]  mat2_q, mat2_d;
    logic [mat_width(I, K, ELEM_W)-1:0]  res_q, res_d;
    logic                                out_valid_q, out_valid_d;
    logic [ELEM_W-1:0]                   res_elem;
    logic                                in_xfer;
    logic                                out_xfer;
    logic                                idx_at_last_r;

    // Ready is a function of state (and reset) only, never of in_valid.
    assign in_ready      = !rst && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign in_xfer       = in_valid && in_ready;
    assign out_xfer      = out_valid_q && out_ready;
    assign idx_at_last_r = (idx_q == IDX_LAST_R);

    mat_flat_unpack #(
        .ROWS   (I),
        .COLS   (K),
        .ELEM_W (ELEM_W),
        .IDX_W  (IDX_W)
    ) u_unpack (
        .flat (res_q),
        .idx  (idx_q),
        .elem (res_elem)
    );

    // Next-state, index and operand/result register updates.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        mat1_d      = mat1_q;
        mat2_d      = mat2_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        case (state_q)
            LOAD_A: begin
                if (in_xfer) begin
                    mat1_d[int'(idx_q) * ELEM_W +: ELEM_W] = in_data;
                    if (idx_q == IDX_LAST_A) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            LOAD_B: begin
                if (in_xfer) begin
                    mat2_d[int'(idx_q) * ELEM_W +: ELEM_W] = in_data;
                    if (idx_q == IDX_LAST_B) begin
                        idx_d   = '0;
                        wcnt_d  = '0;
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            WAIT: begin
                // Capture lands MUL_LATENCY edges after the final mat2 write.
                if (wcnt_q == WCNT_LAST) begin
                    res_d       = matr;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DRAIN;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end

            DRAIN: begin
                if (out_xfer) begin
                    if (idx_at_last_r) begin
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                        state_d     = LOAD_A;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d     = LOAD_A;
                idx_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            wcnt_q      <= '0;
            mat1_q      <= '0;
            mat2_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            mat1_q      <= mat1_d;
            mat2_q      <= mat2_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output data is zeroed whenever nothing is being presented, so it only
    // moves with idx during DRAIN and holds while out_ready is low.
    assign mat1      = mat1_q;
    assign mat2      = mat2_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? res_elem : '0;
    assign out_last  = out_valid_q && idx_at_last_r;

endmodule
